mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch stage's instruction interface and the data-access interface.
- Handshake on every interface: req/addr_ok for the address phase, data_ok/rdata for the response.
- Pipelined: up to DEPTH accepted requests may be outstanding. Responses return in order, and each is routed back to its owner using an in-order tag FIFO.
- Sits between the CPU pipeline and the cache/AXI bridge.

Parameters:
DEPTH, 2, maximum outstanding accepted requests; power of two, ≥1
PTR_W, 1, log2(DEPTH), tag FIFO pointer width; ≥1

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  instruction read request
inst_addr  in  32  instruction address
inst_addr_ok  out  1  instruction address accepted
inst_rdata  out  32  instruction read data
inst_data_ok  out  1  instruction response valid
data_req  in  1  data request
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data address accepted
data_rdata  out  32  data read data
data_data_ok  out  1  data response valid
mem_req  out  1  shared-port request
mem_wr  out  1  shared-port write
mem_size  out  2  shared-port size
mem_addr  out  32  shared-port address
mem_wdata  out  32  shared-port write data
mem_addr_ok  in  1  shared-port address accepted
mem_rdata  in  32  shared-port read data
mem_data_ok  in  1  shared-port response valid
outstanding  out  PTR_W+1  current outstanding count
err  out  1  sticky: mem_data_ok seen with no outstanding request

Behaviour:

Reset:
- Asynchronous on resetn low; no clock required.
- Clears count, FIFO pointers, lock, lock_owner and err.
- All outputs are 0 during reset, including mem_req, the addr_ok/data_ok outputs and outstanding.
- Reset mid-transaction drops all outstanding tags. The downstream side must be reset together with this block.

Grant selection (combinational):
- can_issue = (count < DEPTH). The decision uses the registered count only; a same-cycle pop does not free a slot.
- Priority: if lock = 1, grant = lock_owner. Otherwise grant = data if data_req, else inst if inst_req, else none.
- mem_req = can_issue && the granted requester's req.
- mem_* fields are muxed from the granted requester.
- Inst grant drives mem_wr = 0, mem_size = 2, mem_wdata = 0.
- No grant drives the mem_* fields to 0.

Address accept:
- inst_addr_ok = mem_addr_ok && mem_req && grant==inst; data_addr_ok is defined the same way for data.
- The non-granted requester never sees addr_ok.

Grant lock (registered):
- When mem_req = 1 and mem_addr_ok = 0, set lock = 1 and lock_owner = grant. The grant therefore cannot switch while a request is pending on the shared port.
- Clear lock on mem_addr_ok.
- If the locked owner drops its req, clear lock the next cycle; mem_req is 0 that cycle.

Tag FIFO:
- Push owner (1 = data) on mem_req && mem_addr_ok.
- Pop head on mem_data_ok && count > 0.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- outstanding = count.

Response routing:
- Response latency is 0 cycles (combinational pass-through).
- inst_data_ok = mem_data_ok && count > 0 && head==inst; data_data_ok is defined the same way for data.
- inst_rdata = data_rdata = mem_rdata (broadcast).

Boundary conditions:
- A response that arrives in the same cycle its request is accepted is not possible with count == 0. In that case err is set and the response is dropped.
- With count == DEPTH, mem_req = 0 even if mem_data_ok is high that cycle.
- Starvation of inst under continuous data_req is accepted. The data stage is bounded by the pipeline.

Test Plan:
- inst_req=1, addr 0xBFC00000, mem_addr_ok=1 in the same cycle, mem_data_ok 2 cycles later with rdata 0x3C080001 -> inst_addr_ok=1 for 1 cycle, inst_data_ok=1 with inst_rdata=0x3C080001, data_data_ok=0, outstanding 1→0.
- inst_req and data_req both high (data_wr=1, size 2, addr 0x80001000, wdata 0xDEADBEEF) -> mem_wr=1 with data fields; data_addr_ok=1, inst_addr_ok=0. Next cycle the inst request is issued. Responses return as data then inst, with each data_ok routed correctly.
- inst_req only, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays the inst address (lock). On accept, inst_addr_ok=1. The data request is issued the next cycle.
- DEPTH=2: two accepted requests, no responses -> outstanding=2, mem_req=0 despite pending req. mem_data_ok in the next cycle -> mem_req remains 0 that cycle and returns to 1 the cycle after.
- mem_data_ok=1 with outstanding=0 -> no data_ok output, err=1 and sticky. resetn pulsed low mid-cycle -> err, outstanding and mem_req are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Shares one pipelined SRAM-like port between the instruction and data interfaces.
// Responses return in order and are steered back to their owner by a tag FIFO.
module mem_req_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic [31:0]      inst_addr,
    output logic             inst_addr_ok,
    output logic [31:0]      inst_rdata,
    output logic             inst_data_ok,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic [31:0]      data_rdata,
    output logic             data_data_ok,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_data_ok,
    output logic [PTR_W:0]   outstanding,
    output logic             err
);

    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DEPTH-1:0] tags;
    logic             lock;
    logic             lock_owner;
    logic             err_q;

    logic             grant_valid;
    logic             grant_data;
    logic             grant_req;
    logic             can_issue;
    logic             issue;
    logic             accept;
    logic             have;
    logic             pop;
    logic             head;

    // A pending (not yet accepted) request pins the grant to its owner.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = 1'b0;
        if (lock) begin
            grant_valid = 1'b1;
            grant_data  = lock_owner;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant_data  = 1'b1;
        end else if (inst_req) begin
            grant_valid = 1'b1;
        end
    end

    assign grant_req = grant_valid && (grant_data ? data_req : inst_req);
    assign can_issue = count < (PTR_W+1)'(DEPTH);
    assign issue     = resetn && can_issue && grant_req;
    assign accept    = issue && mem_addr_ok;
    assign have      = count != '0;
    assign pop       = resetn && mem_data_ok && have;
    assign head      = tags[rd_ptr];

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (resetn && grant_valid) begin
            if (grant_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    assign mem_req      = issue;
    assign inst_addr_ok = accept && !grant_data;
    assign data_addr_ok = accept && grant_data;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = resetn ? mem_rdata : 32'd0;
    assign data_rdata   = resetn ? mem_rdata : 32'd0;
    assign outstanding  = count;
    assign err          = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
            // Lock releases on accept, or when the owner withdraws its request.
            if (accept) begin
                lock <= 1'b0;
            end else if (issue) begin
                lock       <= 1'b1;
                lock_owner <= grant_data;
            end else if (lock && !grant_req) begin
                lock <= 1'b0;
            end
            if (mem_data_ok && !have) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tags[wr_ptr] <= grant_data;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: a reference model predicts the shared port each
// cycle, and a monitor matches every routed response against an expected queue.
module tb_mem_req_arbiter;
    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [PTR_W:0] outstanding;
    logic        err;

    mem_req_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
        .mem_data_ok(mem_data_ok), .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Each entry: {owner (1 = data), rdata}.
    logic [32:0] exp_q[$];
    logic [32:0] mem_q[$];
    logic [32:0] mon_e;
    logic        pend_v   = 1'b0;
    logic        pend_own = 1'b0;
    logic        err_m    = 1'b0;
    logic [31:0] acc_rdata = 32'd0;
    logic        acc_inst, acc_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-side driver: answer with the oldest accepted request's data.
    task automatic set_resp(input bit on);
        if (on && mem_q.size() > 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = mem_q[0][31:0];
        end else begin
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
        end
    endtask

    // One clock: check the port against the model at negedge, then advance the model.
    task automatic step();
        int n;
        int ch;
        logic own, er, ewr;
        logic [1:0]  es;
        logic [31:0] ea, ew;
        @(negedge clk);
        n  = mem_q.size();
        ch = pend_v ? (pend_own ? 2 : 1) : (data_req ? 2 : (inst_req ? 1 : 0));
        own = (ch == 2) ? data_req : ((ch == 1) ? inst_req : 1'b0);
        er  = own && (n < DEPTH);
        ewr = 1'b0; es = 2'd0; ea = 32'd0; ew = 32'd0;
        if (ch == 2) begin
            ewr = data_wr; es = data_size; ea = data_addr; ew = data_wdata;
        end else if (ch == 1) begin
            es = 2'd2; ea = inst_addr;
        end
        chk("outstanding", 32'(outstanding), n);
        chk("mem_req", mem_req, er);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wr", mem_wr, ewr);
        chk("mem_size", mem_size, es);
        chk("mem_wdata", mem_wdata, ew);
        chk("inst_addr_ok", inst_addr_ok, er && mem_addr_ok && ch == 1);
        chk("data_addr_ok", data_addr_ok, er && mem_addr_ok && ch == 2);
        chk("err", err, err_m);
        if (mem_data_ok) begin
            if (n > 0) begin
                chk("resp_routed", inst_data_ok | data_data_ok, 1);
                void'(mem_q.pop_front());
            end else begin
                err_m = 1'b1;
            end
        end
        acc_inst = er && mem_addr_ok && ch == 1;
        acc_data = er && mem_addr_ok && ch == 2;
        if (er && mem_addr_ok) begin
            mem_q.push_back({ch == 2, acc_rdata});
            exp_q.push_back({ch == 2, acc_rdata});
            pend_v = 1'b0;
        end else if (er) begin
            pend_v   = 1'b1;
            pend_own = (ch == 2);
        end else if (pend_v && !own) begin
            pend_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every data_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && (inst_data_ok || data_data_ok)) begin
            chk("data_ok_onehot", inst_data_ok & data_data_ok, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got inst=%b data=%b expected none at %0t",
                         inst_data_ok, data_data_ok, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_owner", data_data_ok, mon_e[32]);
                chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, mon_e[31:0]);
            end
        end
    end

    task automatic drain();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_resp(1'b1);
            step();
        end
        set_resp(1'b0);
        step();
        chk("drained", mem_q.size(), 0);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h3C080001;
        #3;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", err, 0);
        #9;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single instruction fetch, response two cycles after accept.
        inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
        acc_rdata = 32'h3C080001;
        step();
        chk("t1_accept", acc_inst, 1);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        step();
        set_resp(1'b1);
        step();
        set_resp(1'b0);

        // Data wins over inst; inst follows next cycle; responses data then inst.
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        mem_addr_ok = 1'b1; acc_rdata = 32'h11111111;
        step();
        chk("t2_data_first", acc_data, 1);
        data_req = 1'b0; acc_rdata = 32'h22222222;
        step();
        chk("t2_inst_next", acc_inst, 1);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        drain();

        // Lock: inst pending three cycles, data arrives meanwhile.
        inst_req = 1'b1; inst_addr = 32'hBFC00010; mem_addr_ok = 1'b0;
        data_wr = 1'b0; data_addr = 32'h80002000;
        step();
        data_req = 1'b1;
        step();
        step();
        mem_addr_ok = 1'b1; acc_rdata = 32'h33333333;
        step();
        chk("t3_inst_locked", acc_inst, 1);
        inst_req = 1'b0; acc_rdata = 32'h44444444;
        step();
        chk("t3_data_after", acc_data, 1);
        drain();

        // Full: two accepted, further request held off even during a response.
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inst_addr = 32'hBFC00100 + 32'(i * 4); acc_rdata = $urandom;
            step();
        end
        inst_addr = 32'hBFC00108;
        step();
        chk("full_count", mem_q.size(), 2);
        set_resp(1'b1);
        step();
        set_resp(1'b0);
        step();
        chk("full_reissue", acc_inst, 1);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if (!inst_req || acc_inst) begin
                inst_req  = ($urandom_range(0, 2) != 0);
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                inst_req = 1'b0;
            end
            if (!data_req || acc_data) begin
                data_req   = ($urandom_range(0, 2) == 0);
                data_wr    = $urandom_range(0, 1);
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                data_req = 1'b0;
            end
            mem_addr_ok = $urandom_range(0, 1);
            acc_rdata   = $urandom;
            set_resp($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Stray response with nothing outstanding: dropped, err sticky.
        mem_data_ok = 1'b1; mem_rdata = 32'h0BAD0BAD;
        step();
        mem_data_ok = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of a cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC00200; mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0; inst_addr = 32'hBFC00204;
        #2;
        chk("pre_rst_mem_req", mem_req, 1);
        chk("pre_rst_outstanding", 32'(outstanding), 1);
        chk("pre_rst_err", err, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_outstanding", 32'(outstanding), 0);
        chk("async_rst_err", err, 0);
        mem_q.delete(); exp_q.delete();
        pend_v = 1'b0; err_m = 1'b0;
        inst_req = 1'b0;
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        step();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
